// File: rtl/exec_sequencer_if.sv
// ============================================================================
// Module      : exec_sequencer_if
// Description : Bundle of receiver, cpu and transmitter-side signals of the
//               instruction-execution sequencer.
//               slave  modport : used by exec_sequencer
//               master modport : used by the environment driving it
//               Signals: inst_in/inst_valid/inst_ready (receiver side),
//               inst_out/proc_clk (cpu side), send_req/tx_ready (transmitter
//               side), busy/pending status, ovf_cnt when
//               EXEC_SEQ_OVF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface exec_sequencer_if #(
   parameter int DEPTH = 4
);
   logic [31:0]                  inst_in;
   logic                         inst_valid;
   logic                         inst_ready;
   logic [31:0]                  inst_out;
   logic                         proc_clk;
   logic                         send_req;
   logic                         tx_ready;
   logic                         busy;
   logic [$clog2(DEPTH+1)-1:0]   pending;
`ifdef EXEC_SEQ_OVF_CNT_EN
   logic [7:0]                   ovf_cnt;

   modport slave (
      input  inst_in, inst_valid, tx_ready,
      output inst_ready, inst_out, proc_clk, send_req, busy, pending, ovf_cnt
   );
   modport master (
      output inst_in, inst_valid, tx_ready,
      input  inst_ready, inst_out, proc_clk, send_req, busy, pending, ovf_cnt
   );
`else
   modport slave (
      input  inst_in, inst_valid, tx_ready,
      output inst_ready, inst_out, proc_clk, send_req, busy, pending
   );
   modport master (
      output inst_in, inst_valid, tx_ready,
      input  inst_ready, inst_out, proc_clk, send_req, busy, pending
   );
`endif
endinterface

`default_nettype wire

// File: rtl/exec_sequencer.sv
// ============================================================================
// Module      : exec_sequencer
// Description : Buffers received instructions in a FIFO and runs each one
//               through the cpu with a gated, divided processor clock, then
//               requests one register-file dump from the transmitter.
//               Ports: clk12 (system clock), rst (async, active-high),
//               bus (exec_sequencer_if.slave: inst_in/inst_valid/inst_ready,
//               inst_out/proc_clk, send_req/tx_ready, busy, pending, ovf_cnt).
//               Optional feature macro: EXEC_SEQ_OVF_CNT_EN enables the
//               saturating dropped-instruction counter on bus.ovf_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_sequencer #(
   parameter int          DEPTH      = 4,
   parameter int          CLK_DIV    = 2,
   parameter int          EXEC_CLKS  = 10,
   parameter int          ISSUE_CLKS = 2,
   parameter logic [31:0] NOOP       = 32'h13000000
) (
   input  wire logic          clk12,
   input  wire logic          rst,
   exec_sequencer_if.slave    bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);
   // One spare bit so that CLK_DIV == EXEC_CLKS still fits in the counter.
   localparam int CW = $clog2(EXEC_CLKS + 1);

   localparam logic [OW-1:0] c_full  = OW'(DEPTH);
   localparam logic [CW-1:0] c_last  = CW'(EXEC_CLKS - 1);
   localparam logic [CW-1:0] c_issue = CW'(ISSUE_CLKS);
   localparam logic [CW-1:0] c_div   = CW'(CLK_DIV);
   localparam logic [CW-1:0] c_half  = CW'(CLK_DIV / 2);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC    = 2'd1,
      ST_SEND    = 2'd2,
      ST_WAIT_TX = 2'd3
   } state_t;

   // ------------------------------------------------------------------ FIFO
   logic [31:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [OW-1:0] count_q, count_d;
   logic          w_full, w_empty, w_push, w_pop;

   // Full is taken from the registered count, so a strobe while full is
   // dropped even when the sequencer pops in the same cycle.
   assign w_full  = (count_q == c_full);
   assign w_empty = (count_q == '0);
   assign w_push  = bus.inst_valid && !w_full;

   always_comb begin
      count_d = count_q;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + OW'(1);
         2'b01:   count_d = count_q - OW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk12) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= bus.inst_in;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk12 or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   // ------------------------------------------------------------------- FSM
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   inst_reg_q, inst_reg_d;
   logic [31:0]   inst_out_q, inst_out_d;
   logic          proc_clk_q, proc_clk_d;
   logic          send_req_q, send_req_d;
   logic          tx_low_seen_q, tx_low_seen_d;

   // Outputs are registered, so they are computed here from the next counter
   // value; outside EXEC the cpu sees NOOP and a clock parked high.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      inst_reg_d    = inst_reg_q;
      inst_out_d    = NOOP;
      proc_clk_d    = 1'b1;
      send_req_d    = 1'b0;
      tx_low_seen_d = tx_low_seen_q;
      w_pop         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop      = 1'b1;
               inst_reg_d = mem_q[rd_ptr_q];
               cnt_d      = '0;
               state_d    = ST_EXEC;
               inst_out_d = (c_issue != '0) ? mem_q[rd_ptr_q] : NOOP;
            end
         end
         ST_EXEC: begin
            if (cnt_q == c_last) begin
               // Final half-period ends high: that is the last rising edge.
               state_d = ST_SEND;
            end else begin
               cnt_d      = cnt_q + CW'(1);
               inst_out_d = (cnt_d < c_issue) ? inst_reg_q : NOOP;
               proc_clk_d = ((cnt_d % c_div) < c_half);
            end
         end
         ST_SEND: begin
            if (bus.tx_ready) begin
               send_req_d    = 1'b1;
               tx_low_seen_d = 1'b0;
               state_d       = ST_WAIT_TX;
            end
         end
         ST_WAIT_TX: begin
            // Leave only after the transmitter has visibly gone busy and
            // come back, so the next instruction never overlaps a dump.
            if (!tx_low_seen_q) begin
               if (!bus.tx_ready) tx_low_seen_d = 1'b1;
            end else if (bus.tx_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk12 or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         inst_reg_q    <= NOOP;
         inst_out_q    <= NOOP;
         proc_clk_q    <= 1'b1;
         send_req_q    <= 1'b0;
         tx_low_seen_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         inst_reg_q    <= inst_reg_d;
         inst_out_q    <= inst_out_d;
         proc_clk_q    <= proc_clk_d;
         send_req_q    <= send_req_d;
         tx_low_seen_q <= tx_low_seen_d;
      end
   end

   assign bus.inst_ready = !w_full;
   assign bus.inst_out   = inst_out_q;
   assign bus.proc_clk   = proc_clk_q;
   assign bus.send_req   = send_req_q;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.pending    = count_q;

`ifdef EXEC_SEQ_OVF_CNT_EN
   logic [7:0] ovf_cnt_q;

   always_ff @(posedge clk12 or posedge rst) begin
      if (rst) begin
         ovf_cnt_q <= '0;
      end else if (bus.inst_valid && w_full && (ovf_cnt_q != 8'hFF)) begin
         ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
   end

   assign bus.ovf_cnt = ovf_cnt_q;
`endif

endmodule

`default_nettype wire
